// File: rtl/ptgc_assoc_cache_if.sv
// Bus bundle for the PTG cache: lookup request/response, group fill,
// single-entry invalidate and invalidate-all control.
//   slave  : the cache side (takes *_i, drives *_o)
//   master : the walker / memory-port side
// Signal names keep the _i/_o suffixes as seen from the cache.
interface ptgc_assoc_cache_if #(
    parameter int PTES = 8,
    parameter int AW   = 32
);
    localparam int IW = (PTES > 1) ? $clog2(PTES) : 1;

    // lookup request
    logic                  req_v_i;
    logic                  req_rdy_o;
    logic [AW-1:0]         req_dadr_i;
    logic [47:0]           req_vpn_i;
    logic [9:0]            req_asid_i;
    // lookup response
    logic                  rsp_v_o;
    logic                  rsp_ptg_hit_o;
    logic                  rsp_pte_hit_o;
    logic [IW-1:0]         rsp_idx_o;
    logic [127:0]          rsp_pte_o;
    // fill
    logic                  fill_v_i;
    logic [AW-1:0]         fill_dadr_i;
    logic [PTES*128-1:0]   fill_ptg_i;
    // invalidate
    logic                  inv_v_i;
    logic [AW-1:0]         inv_dadr_i;
    logic                  inv_all_i;
    logic                  busy_o;

    modport slave (
        input  req_v_i, req_dadr_i, req_vpn_i, req_asid_i,
        input  fill_v_i, fill_dadr_i, fill_ptg_i,
        input  inv_v_i, inv_dadr_i, inv_all_i,
        output req_rdy_o, rsp_v_o, rsp_ptg_hit_o, rsp_pte_hit_o,
        output rsp_idx_o, rsp_pte_o, busy_o
    );

    modport master (
        output req_v_i, req_dadr_i, req_vpn_i, req_asid_i,
        output fill_v_i, fill_dadr_i, fill_ptg_i,
        output inv_v_i, inv_dadr_i, inv_all_i,
        input  req_rdy_o, rsp_v_o, rsp_ptg_hit_o, rsp_pte_hit_o,
        input  rsp_idx_o, rsp_pte_o, busy_o
    );
endinterface

// File: rtl/ptgc_assoc_cache.sv
// Fully associative page-table-group cache for the hash-table walker.
// DEP entries, each one PTG of PTES 128-bit HPTEs tagged by its physical
// address (dadr). Two-stage lookup: stage 1 matches the group tag and
// snapshots the group, stage 2 selects the lowest-index matching HPTE.
// Fills pick an existing tag, else the lowest invalid entry, else a
// round-robin victim. Invalidate-all walks the entries one per cycle.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : ptgc_assoc_cache_if.slave (request/response/fill/inv)
module ptgc_assoc_cache #(
    parameter int DEP  = 8,
    parameter int PTES = 8,
    parameter int AW   = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    ptgc_assoc_cache_if.slave bus
);
    localparam int IW = (PTES > 1) ? $clog2(PTES) : 1;
    localparam int EW = $clog2(DEP);
    localparam int PW = PTES * 128;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    // entry storage
    logic [DEP-1:0] valid_q;
    logic [AW-1:0]  tag_q  [DEP];
    logic [PW-1:0]  data_q [DEP];

    logic [0:0]     state_q;
    logic [EW-1:0]  cnt_q;
    logic [EW-1:0]  rr_q;

    logic busy;
    logic req_acc;

    assign busy          = (state_q == S_SWEEP);
    assign bus.busy_o    = busy;
    assign bus.req_rdy_o = !busy;
    assign req_acc       = bus.req_v_i && !busy;

    // ---------------------------------------------------------------
    // Tag searches. Loops run high-to-low so the lowest index wins.
    // ---------------------------------------------------------------
    logic          lk_hit;
    logic [EW-1:0] lk_idx;
    logic          fm_hit;
    logic [EW-1:0] fm_idx;
    logic          fi_any;
    logic [EW-1:0] fi_idx;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        fm_hit = 1'b0;
        fm_idx = '0;
        fi_any = 1'b0;
        fi_idx = '0;
        for (int i = DEP - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == bus.req_dadr_i) begin
                lk_hit = 1'b1;
                lk_idx = EW'(i);
            end
            if (valid_q[i] && tag_q[i] == bus.fill_dadr_i) begin
                fm_hit = 1'b1;
                fm_idx = EW'(i);
            end
            if (!valid_q[i]) begin
                fi_any = 1'b1;
                fi_idx = EW'(i);
            end
        end
    end

    // A fill is dropped while sweeping, when a sweep starts this cycle, or
    // when an invalidate hits the same address (the invalidate wins).
    logic          fill_go;
    logic          rr_adv;
    logic [EW-1:0] victim;

    assign fill_go = bus.fill_v_i && !busy && !bus.inv_all_i &&
                     !(bus.inv_v_i && bus.inv_dadr_i == bus.fill_dadr_i);
    assign victim  = fm_hit ? fm_idx : (fi_any ? fi_idx : rr_q);
    assign rr_adv  = fill_go && !fm_hit && !fi_any;

    // ---------------------------------------------------------------
    // Valid bits, round-robin pointer and invalidate-all sweep.
    // The fill update comes after the invalidate loop so a fill whose
    // victim happens to carry the invalidated tag still lands valid.
    // ---------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            valid_q <= '0;
        end else if (state_q == S_SWEEP) begin
            valid_q[cnt_q] <= 1'b0;
            cnt_q          <= cnt_q + 1'b1;
            if (cnt_q == EW'(DEP - 1)) begin
                state_q <= S_IDLE;
                rr_q    <= '0;
            end
        end else begin
            if (bus.inv_all_i) begin
                state_q <= S_SWEEP;
                cnt_q   <= '0;
            end
            if (bus.inv_v_i) begin
                for (int i = 0; i < DEP; i++) begin
                    if (tag_q[i] == bus.inv_dadr_i) valid_q[i] <= 1'b0;
                end
            end
            if (fill_go) valid_q[victim] <= 1'b1;
            if (rr_adv)  rr_q <= rr_q + 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide
    // whether their contents are ever observed.
    always_ff @(posedge clk_i) begin
        if (fill_go) begin
            tag_q[victim]  <= bus.fill_dadr_i;
            data_q[victim] <= bus.fill_ptg_i;
        end
    end

    // ---------------------------------------------------------------
    // Stage 1: group tag match and snapshot of the matching group.
    // ---------------------------------------------------------------
    logic          s1_v;
    logic          s1_hit;
    logic [PW-1:0] s1_data;
    logic [47:0]   s1_vpn;
    logic [9:0]    s1_asid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v    <= 1'b0;
            s1_hit  <= 1'b0;
            s1_data <= '0;
            s1_vpn  <= '0;
            s1_asid <= '0;
        end else begin
            s1_v <= req_acc;
            if (req_acc) begin
                s1_hit  <= lk_hit;
                s1_data <= lk_hit ? data_q[lk_idx] : '0;
                s1_vpn  <= bus.req_vpn_i;
                s1_asid <= bus.req_asid_i;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: HPTE select. Fields: v=31, vpn=47:32, g=53, asid=63:54,
    // vpnhi=127:96; {vpnhi,vpn} is compared against the 48-bit VPN.
    // ---------------------------------------------------------------
    logic          sel_hit;
    logic [IW-1:0] sel_idx;
    logic [127:0]  sel_pte;

    always_comb begin : pte_select
        logic [127:0] pte;
        sel_hit = 1'b0;
        sel_idx = '0;
        sel_pte = '0;
        pte     = '0;
        for (int p = PTES - 1; p >= 0; p--) begin
            pte = s1_data[p*128 +: 128];
            if (pte[31] && {pte[127:96], pte[47:32]} == s1_vpn &&
                (pte[53] || pte[63:54] == s1_asid)) begin
                sel_hit = 1'b1;
                sel_idx = IW'(p);
                sel_pte = pte;
            end
        end
    end

    logic pte_hit;
    assign pte_hit = sel_hit && s1_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.rsp_v_o       <= 1'b0;
            bus.rsp_ptg_hit_o <= 1'b0;
            bus.rsp_pte_hit_o <= 1'b0;
            bus.rsp_idx_o     <= '0;
            bus.rsp_pte_o     <= '0;
        end else begin
            bus.rsp_v_o <= s1_v;
            if (s1_v) begin
                bus.rsp_ptg_hit_o <= s1_hit;
                bus.rsp_pte_hit_o <= pte_hit;
                bus.rsp_idx_o     <= pte_hit ? sel_idx : '0;
                bus.rsp_pte_o     <= pte_hit ? sel_pte : '0;
            end
        end
    end
endmodule

// File: tb/tb_ptgc_assoc_cache.sv
// Self-checking bench for ptgc_assoc_cache. A behavioural model (arrays of
// valid/tag/HPTEs, a round-robin index and a busy countdown) predicts each
// response at accept time; responses are expected two edges later.
module tb_ptgc_assoc_cache;
    localparam int DEP  = 8;
    localparam int PTES = 8;
    localparam int AW   = 32;
    localparam int IW   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ptgc_assoc_cache_if #(.PTES(PTES), .AW(AW)) bus ();

    ptgc_assoc_cache #(.DEP(DEP), .PTES(PTES), .AW(AW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic          v;
        logic          ptg;
        logic          hit;
        logic [IW-1:0] idx;
        logic [127:0]  pte;
    } rsp_t;

    // reference model state
    bit            m_valid [DEP];
    bit [AW-1:0]   m_tag   [DEP];
    logic [127:0]  m_pte   [DEP][PTES];
    int            m_rr;
    int            m_busy;
    rsp_t          pipe0;
    rsp_t          exp_out;

    int checks = 0;
    int errors = 0;

    logic [47:0] vpn_pool  [4];
    logic [9:0]  asid_pool [4];

    function automatic rsp_t model_lookup(input logic [AW-1:0] dadr,
                                          input logic [47:0] vpn,
                                          input logic [9:0] asid);
        rsp_t r;
        logic [127:0] e;
        r   = '0;
        r.v = 1'b1;
        for (int i = 0; i < DEP; i++) begin
            if (m_valid[i] && m_tag[i] == dadr) begin
                r.ptg = 1'b1;
                for (int p = 0; p < PTES; p++) begin
                    e = m_pte[i][p];
                    if (e[31] == 1'b1 && e[127:96] == vpn[47:16] && e[47:32] == vpn[15:0] &&
                        (e[53] == 1'b1 || e[63:54] == asid)) begin
                        r.hit = 1'b1;
                        r.idx = IW'(p);
                        r.pte = e;
                        return r;
                    end
                end
                return r;
            end
        end
        return r;
    endfunction

    function automatic rsp_t masked(input rsp_t r);
        rsp_t m;
        m = r;
        if (r.v !== 1'b1) m = {r.v, {($bits(rsp_t) - 1){1'b0}}};
        else if (r.hit !== 1'b1) m.idx = '0;
        return m;
    endfunction

    function automatic rsp_t dut_rsp();
        rsp_t r;
        r.v   = bus.rsp_v_o;
        r.ptg = bus.rsp_ptg_hit_o;
        r.hit = bus.rsp_pte_hit_o;
        r.idx = bus.rsp_idx_o;
        r.pte = bus.rsp_pte_o;
        return r;
    endfunction

    function automatic logic [127:0] rand_pte();
        logic [127:0] e;
        logic [47:0]  vpn;
        e = {$urandom, $urandom, $urandom, $urandom};
        vpn = vpn_pool[$urandom_range(0, 3)];
        e[31]     = ($urandom_range(0, 3) != 0);
        e[127:96] = vpn[47:16];
        e[47:32]  = vpn[15:0];
        e[63:54]  = asid_pool[$urandom_range(0, 3)];
        e[53]     = ($urandom_range(0, 3) == 0);
        return e;
    endfunction

    function automatic logic [PTES*128-1:0] rand_ptg();
        logic [PTES*128-1:0] g;
        for (int p = 0; p < PTES; p++) g[p*128 +: 128] = rand_pte();
        return g;
    endfunction

    task automatic idle_inputs();
        bus.req_v_i     = 1'b0;
        bus.req_dadr_i  = '0;
        bus.req_vpn_i   = '0;
        bus.req_asid_i  = '0;
        bus.fill_v_i    = 1'b0;
        bus.fill_dadr_i = '0;
        bus.fill_ptg_i  = '0;
        bus.inv_v_i     = 1'b0;
        bus.inv_dadr_i  = '0;
        bus.inv_all_i   = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        m_rr    = 0;
        m_busy  = 0;
        pipe0   = '0;
        exp_out = '0;
    endtask

    // Apply this cycle's inputs to the model and return the response the
    // request (if accepted) will produce.
    task automatic model_edge(output rsp_t r);
        int  victim;
        bit  fill_ok;
        r = '0;
        if (bus.req_v_i && m_busy == 0)
            r = model_lookup(bus.req_dadr_i, bus.req_vpn_i, bus.req_asid_i);
        if (m_busy > 0) begin
            m_busy--;
        end else begin
            fill_ok = bus.fill_v_i && !bus.inv_all_i &&
                      !(bus.inv_v_i && bus.inv_dadr_i == bus.fill_dadr_i);
            victim = -1;
            if (fill_ok) begin
                for (int i = 0; i < DEP; i++)
                    if (victim < 0 && m_valid[i] && m_tag[i] == bus.fill_dadr_i) victim = i;
                for (int i = 0; i < DEP; i++)
                    if (victim < 0 && !m_valid[i]) victim = i;
                if (victim < 0) begin
                    victim = m_rr;
                    m_rr   = (m_rr + 1) % DEP;
                end
            end
            if (bus.inv_v_i)
                for (int i = 0; i < DEP; i++)
                    if (m_tag[i] == bus.inv_dadr_i) m_valid[i] = 1'b0;
            if (fill_ok) begin
                m_valid[victim] = 1'b1;
                m_tag[victim]   = bus.fill_dadr_i;
                for (int p = 0; p < PTES; p++) m_pte[victim][p] = bus.fill_ptg_i[p*128 +: 128];
            end
            if (bus.inv_all_i) begin
                for (int i = 0; i < DEP; i++) m_valid[i] = 1'b0;
                m_busy = DEP;
                m_rr   = 0;
            end
        end
    endtask

    task automatic step();
        rsp_t r;
        model_edge(r);
        @(posedge clk);
        #1;
        exp_out = pipe0;
        pipe0   = r;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill(input logic [AW-1:0] dadr, input logic [PTES*128-1:0] ptg);
        idle_inputs();
        bus.fill_v_i    = 1'b1;
        bus.fill_dadr_i = dadr;
        bus.fill_ptg_i  = ptg;
        step();
        idle_inputs();
    endtask

    // Issue one lookup and capture the DUT response two edges later along
    // with the model's prediction.
    task automatic lookup(input logic [AW-1:0] dadr, input logic [47:0] vpn,
                          input logic [9:0] asid, output rsp_t got, output rsp_t exp);
        idle_inputs();
        bus.req_v_i    = 1'b1;
        bus.req_dadr_i = dadr;
        bus.req_vpn_i  = vpn;
        bus.req_asid_i = asid;
        step();
        idle_inputs();
        step();
        got = dut_rsp();
        exp = exp_out;
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset();
        rsp_t got, exp;
        do_reset();
        checks++;
        if (dut_rsp() !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got %h expected 0", dut_rsp());
        end
        checks++;
        if (bus.busy_o !== 1'b0 || bus.req_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_rdy: got busy=%b rdy=%b expected busy=0 rdy=1", bus.busy_o, bus.req_rdy_o);
        end
        bus.req_v_i    = 1'b1;
        bus.req_dadr_i = 32'h1000;
        step();
        idle_inputs();
        checks++;
        if (bus.rsp_v_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_lookup_early: got rsp_v=%b expected 0", bus.rsp_v_o);
        end
        step();
        got = dut_rsp();
        checks++;
        if (got !== rsp_t'({1'b1, 1'b0, 1'b0, {IW{1'b0}}, 128'h0})) begin
            errors++;
            $display("FAIL reset_lookup_miss: got %h expected v=1 miss pte=0", got);
        end
        step();
        checks++;
        if (bus.rsp_v_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_lookup_pulse: got rsp_v=%b expected 0", bus.rsp_v_o);
        end
        exp = exp_out;
    endtask

    task automatic test_fill_hit();
        logic [PTES*128-1:0] ptg;
        logic [127:0] pte3;
        rsp_t got, exp;
        ptg = rand_ptg();
        for (int p = 0; p < PTES; p++) ptg[p*128 + 31] = 1'b0;
        pte3 = {$urandom, $urandom, $urandom, $urandom};
        pte3[31] = 1'b1; pte3[127:96] = '0; pte3[47:32] = 16'h0042;
        pte3[63:54] = 10'd5; pte3[53] = 1'b0;
        ptg[3*128 +: 128] = pte3;
        do_fill(32'h1000, ptg);
        lookup(32'h1000, 48'h42, 10'd5, got, exp);
        checks++;
        if (masked(got) !== masked(exp)) begin
            errors++;
            $display("FAIL fill_hit_model: got %h expected %h", got, exp);
        end
        checks++;
        if (got.ptg !== 1'b1 || got.hit !== 1'b1 || got.idx !== 3'd3 || got.pte !== pte3) begin
            errors++;
            $display("FAIL fill_hit_pte3: got %h expected ptg=1 hit=1 idx=3 pte=%h", got, pte3);
        end
        lookup(32'h1000, 48'h42, 10'd6, got, exp);
        checks++;
        if (got.ptg !== 1'b1 || got.hit !== 1'b0 || got.pte !== '0) begin
            errors++;
            $display("FAIL fill_asid_miss: got %h expected ptg=1 hit=0 pte=0", got);
        end
        pte3[53] = 1'b1;
        ptg[3*128 +: 128] = pte3;
        do_fill(32'h1000, ptg);
        lookup(32'h1000, 48'h42, 10'd6, got, exp);
        checks++;
        if (got.hit !== 1'b1 || got.idx !== 3'd3 || got.pte !== pte3 || masked(got) !== masked(exp)) begin
            errors++;
            $display("FAIL fill_global_hit: got %h expected hit idx=3 pte=%h", got, pte3);
        end
    endtask

    task automatic test_replacement();
        rsp_t got, exp;
        logic [AW-1:0] a [DEP];
        do_reset();
        for (int i = 0; i < DEP; i++) begin
            a[i] = 32'h10000 + 32'(i) * 32'h1000;
            do_fill(a[i], rand_ptg());
        end
        do_fill(32'h90000, rand_ptg());
        lookup(a[0], vpn_pool[0], asid_pool[0], got, exp);
        checks++;
        if (got.ptg !== 1'b0 || masked(got) !== masked(exp)) begin
            errors++;
            $display("FAIL repl_9th_evicts_0: got %h expected ptg=0", got);
        end
        lookup(a[1], vpn_pool[1], asid_pool[1], got, exp);
        checks++;
        if (got.ptg !== 1'b1 || masked(got) !== masked(exp)) begin
            errors++;
            $display("FAIL repl_9th_keeps_1: got %h expected %h", got, exp);
        end
        do_fill(32'hA0000, rand_ptg());
        lookup(a[1], vpn_pool[1], asid_pool[1], got, exp);
        checks++;
        if (got.ptg !== 1'b0) begin
            errors++;
            $display("FAIL repl_10th_evicts_1: got ptg=%b expected 0", got.ptg);
        end
        // Refilling a resident tag must not move the pointer: the next new
        // tag evicts entry 2, not entry 3.
        do_fill(a[3], rand_ptg());
        do_fill(32'hB0000, rand_ptg());
        lookup(a[2], vpn_pool[2], asid_pool[2], got, exp);
        checks++;
        if (got.ptg !== 1'b0) begin
            errors++;
            $display("FAIL repl_refill_rr_evict: got ptg=%b expected 0", got.ptg);
        end
        lookup(a[3], vpn_pool[3], asid_pool[3], got, exp);
        checks++;
        if (got.ptg !== 1'b1 || masked(got) !== masked(exp)) begin
            errors++;
            $display("FAIL repl_refill_resident: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [PTES*128-1:0] ptg;
        logic [127:0] e;
        bit exp_v   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bit exp_ptg [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        rsp_t got;
        ptg = rand_ptg();
        e = ptg[127:0];
        e[31] = 1'b1; e[53] = 1'b1;
        e[127:96] = vpn_pool[0][47:16]; e[47:32] = vpn_pool[0][15:0];
        ptg[127:0] = e;
        idle_inputs();
        step();
        step();
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            if (c < 4) begin
                bus.req_v_i    = 1'b1;
                bus.req_dadr_i = 32'h7000;
                bus.req_vpn_i  = vpn_pool[0];
                bus.req_asid_i = asid_pool[1];
            end
            if (c == 1) begin
                bus.fill_v_i    = 1'b1;
                bus.fill_dadr_i = 32'h7000;
                bus.fill_ptg_i  = ptg;
            end
            step();
            got = dut_rsp();
            checks++;
            if (got.v !== exp_v[c] || (exp_v[c] && got.ptg !== exp_ptg[c]) ||
                masked(got) !== masked(exp_out)) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %h expected v=%b ptg=%b model %h",
                         c, got, exp_v[c], exp_ptg[c], exp_out);
            end
        end
        idle_inputs();
    endtask

    task automatic test_sweep();
        rsp_t got, exp;
        do_reset();
        for (int i = 0; i < DEP; i++) do_fill(32'h20000 + 32'(i) * 32'h100, rand_ptg());
        bus.inv_all_i = 1'b1;
        step();
        for (int c = 0; c < DEP; c++) begin
            checks++;
            if (bus.busy_o !== 1'b1 || bus.req_rdy_o !== 1'b0 || m_busy == 0) begin
                errors++;
                $display("FAIL sweep_busy_c%0d: got busy=%b rdy=%b expected busy=1 rdy=0", c, bus.busy_o, bus.req_rdy_o);
            end
            idle_inputs();
            bus.req_v_i     = 1'b1;
            bus.req_dadr_i  = 32'h20000;
            bus.fill_v_i    = 1'b1;
            bus.fill_dadr_i = 32'h30000 + 32'(c);
            bus.fill_ptg_i  = rand_ptg();
            bus.inv_all_i   = (c == 2);
            step();
        end
        idle_inputs();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.req_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL sweep_end: got busy=%b rdy=%b expected busy=0 rdy=1", bus.busy_o, bus.req_rdy_o);
        end
        for (int i = 0; i < 3; i++) begin
            lookup(32'h20000 + 32'(i) * 32'h300, vpn_pool[i], asid_pool[i], got, exp);
            checks++;
            if (got.ptg !== 1'b0) begin
                errors++;
                $display("FAIL sweep_all_miss_%0d: got ptg=%b expected 0", i, got.ptg);
            end
        end
        lookup(32'h30001, vpn_pool[0], asid_pool[0], got, exp);
        checks++;
        if (got.ptg !== 1'b0) begin
            errors++;
            $display("FAIL sweep_fill_dropped: got ptg=%b expected 0", got.ptg);
        end
        do_fill(32'h40000, rand_ptg());
        lookup(32'h40000, vpn_pool[1], asid_pool[1], got, exp);
        checks++;
        if (got.ptg !== 1'b1 || masked(got) !== masked(exp)) begin
            errors++;
            $display("FAIL sweep_refill: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_inv_fill();
        rsp_t got, exp;
        do_fill(32'h2000, rand_ptg());
        bus.inv_v_i     = 1'b1;
        bus.inv_dadr_i  = 32'h2000;
        bus.fill_v_i    = 1'b1;
        bus.fill_dadr_i = 32'h2000;
        bus.fill_ptg_i  = rand_ptg();
        step();
        lookup(32'h2000, vpn_pool[0], asid_pool[0], got, exp);
        checks++;
        if (got.ptg !== 1'b0) begin
            errors++;
            $display("FAIL inv_fill_same: got ptg=%b expected 0", got.ptg);
        end
        do_fill(32'h2100, rand_ptg());
        bus.inv_v_i     = 1'b1;
        bus.inv_dadr_i  = 32'h2100;
        bus.fill_v_i    = 1'b1;
        bus.fill_dadr_i = 32'h2200;
        bus.fill_ptg_i  = rand_ptg();
        step();
        lookup(32'h2100, vpn_pool[0], asid_pool[0], got, exp);
        checks++;
        if (got.ptg !== 1'b0) begin
            errors++;
            $display("FAIL inv_fill_diff_inv: got ptg=%b expected 0", got.ptg);
        end
        lookup(32'h2200, vpn_pool[2], asid_pool[2], got, exp);
        checks++;
        if (got.ptg !== 1'b1 || masked(got) !== masked(exp)) begin
            errors++;
            $display("FAIL inv_fill_diff_fill: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_reset_mid_sweep();
        rsp_t got, exp;
        do_fill(32'h5000, rand_ptg());
        do_fill(32'h5100, rand_ptg());
        bus.inv_all_i = 1'b1;
        step();
        idle_inputs();
        step();
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || dut_rsp() !== '0) begin
            errors++;
            $display("FAIL midsweep_reset: got busy=%b rsp=%h expected busy=0 rsp=0", bus.busy_o, dut_rsp());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lookup(32'h5100, vpn_pool[0], asid_pool[0], got, exp);
        checks++;
        if (got.ptg !== 1'b0 || bus.req_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL midsweep_after: got ptg=%b rdy=%b expected ptg=0 rdy=1", got.ptg, bus.req_rdy_o);
        end
    endtask

    task automatic test_random();
        rsp_t got;
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            bus.req_v_i    = ($urandom_range(0, 9) < 6);
            bus.req_dadr_i = 32'h8000 + 32'($urandom_range(0, 11)) * 32'h40;
            bus.req_vpn_i  = vpn_pool[$urandom_range(0, 3)];
            bus.req_asid_i = asid_pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) begin
                bus.fill_v_i    = 1'b1;
                bus.fill_dadr_i = 32'h8000 + 32'($urandom_range(0, 11)) * 32'h40;
                bus.fill_ptg_i  = rand_ptg();
            end
            if ($urandom_range(0, 9) == 0) begin
                bus.inv_v_i    = 1'b1;
                bus.inv_dadr_i = 32'h8000 + 32'($urandom_range(0, 11)) * 32'h40;
            end
            bus.inv_all_i = ($urandom_range(0, 99) == 0);
            step();
            got = dut_rsp();
            checks++;
            if (masked(got) !== masked(exp_out) || bus.busy_o !== (m_busy > 0) ||
                bus.req_rdy_o !== (m_busy == 0)) begin
                errors++;
                $display("FAIL random_c%0d: got %h busy=%b expected %h busy=%b",
                         c, got, bus.busy_o, exp_out, (m_busy > 0));
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            vpn_pool[i]  = {$urandom, $urandom};
            asid_pool[i] = 10'($urandom);
        end
        vpn_pool[0] = 48'h42;
        idle_inputs();
        model_reset();
        test_reset();
        test_fill_hit();
        test_replacement();
        test_back_to_back();
        test_sweep();
        test_inv_fill();
        test_reset_mid_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ptgc_assoc_cache.md
Name: ptgc_assoc_cache

Overview:
- Parametrised successor to the fixed 8-entry page-table-group cache used by the hash-table walker.
- Fully associative cache of DEP page table groups (PTGs), each holding PTES hash page table entries in HPTE format (128 bits).
- Two-stage pipelined lookup: a group tag compare on dadr, then a PTE select on VPN/ASID.
- Supports fill with invalid-first / round-robin victim selection, single-entry invalidate, and a multi-cycle invalidate-all sweep. Sits between the MMU walker FSM and the memory port.

Parameters:
DEP, 8, number of cached PTGs (power of 2, >=2)
PTES, 8, HPTEs per PTG (power of 2, >=1)
AW, 32, physical address width of dadr

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_v_i  in  1  lookup request valid
req_rdy_o  out  1  lookup can be accepted
req_dadr_i  in  AW  PTG address (tag)
req_vpn_i  in  48  virtual page number {vpnhi,vpn}
req_asid_i  in  10  address space id
rsp_v_o  out  1  response valid
rsp_ptg_hit_o  out  1  group tag matched a valid entry
rsp_pte_hit_o  out  1  matching valid PTE found
rsp_idx_o  out  $clog2(PTES)  index of matching PTE
rsp_pte_o  out  128  matching HPTE (0 on miss)
fill_v_i  in  1  write a group
fill_dadr_i  in  AW  group address
fill_ptg_i  in  PTES*128  group data, PTE0 in LSBs
inv_v_i  in  1  invalidate entry whose tag == inv_dadr_i
inv_dadr_i  in  AW  invalidate address
inv_all_i  in  1  start invalidate-all sweep
busy_o  out  1  sweep in progress

Behaviour:
- Reset: all entry valid bits = 0, rr_ptr = 0, sweep FSM = IDLE. Outputs: rsp_v_o = 0, rsp_ptg_hit_o = 0, rsp_pte_hit_o = 0, rsp_idx_o = 0, rsp_pte_o = 0, busy_o = 0, req_rdy_o = 1 once reset is released. Reset mid-sweep or mid-lookup aborts immediately.
- HPTE fields (bit positions):
  - v = 31
  - vpn = 47:32
  - g = 53
  - asid = 63:54
  - vpnhi = 127:96
- Lookup pipeline:
  - Accepted when req_v_i & req_rdy_o; one accept per cycle.
  - req_rdy_o = !busy_o.
  - Stage 1 (edge 1): compare req_dadr_i against all valid tags. Register the hit flag, the lowest matching entry's PTG data, and the request VPN/ASID.
  - Stage 2 (edge 2): a PTE matches when pte.v & {vpnhi,vpn}==vpn & (g | asid==req_asid). The lowest-index match wins. Register rsp_* outputs.
  - rsp_v_o is a one-cycle pulse two cycles after accept. No backpressure.
  - rsp_pte_hit_o = 0 whenever rsp_ptg_hit_o = 0.
  - Lookups in flight when a sweep starts complete normally on their snapshot.
- Fill (one cycle, ignored while busy_o):
  - If fill_dadr_i matches a valid tag, overwrite that entry; rr_ptr unchanged.
  - Otherwise the victim is the lowest-index invalid entry, if any; rr_ptr unchanged.
  - Otherwise the victim is rr_ptr, and rr_ptr increments, wrapping DEP-1 -> 0.
  - The entry is set valid with the new tag and data.
- Single invalidate: clears the valid bit of every entry whose tag == inv_dadr_i. One cycle; ignored while busy_o.
- Same-cycle priority:
  - Invalidate and fill at the same address: the invalidate wins; the entry ends invalid, and the fill consumes no victim or pointer.
  - Invalidate and fill at different addresses: both take effect.
  - Lookup and fill/invalidate: stage 1 compares against contents before the write. The new contents are visible to a request accepted on the next cycle.
- Sweep FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on inv_all_i, with cnt = 0 and busy_o = 1 from the next cycle.
  - SWEEP clears valid[cnt] each cycle. When cnt == DEP-1, the FSM goes to IDLE, busy_o falls and rr_ptr = 0.
  - A sweep takes exactly DEP cycles. inv_all_i is ignored during SWEEP.
  - inv_all_i in the same cycle as a fill: the sweep starts and the fill is dropped.

Test Plan:
- Reset, then lookup dadr=0x1000 -> rsp_v_o at cycle +2 with ptg_hit=0, pte_hit=0, pte=0; req_rdy_o=1.
- Fill dadr=0x1000 with PTE3 = {v=1, vpnhi=0, vpn=0x0042, asid=5, g=0}. Lookup vpn=0x42, asid=5 -> ptg_hit=1, pte_hit=1, idx=3, pte equals PTE3. Lookup asid=6 -> pte_hit=0. Set g=1 and refill -> asid=6 hits.
- Fill 8 distinct dadr values (DEP=8) -> entries 0..7, rr_ptr=0. A 9th fill replaces entry 0 and rr_ptr=1. A 10th fill replaces entry 1. Refilling a resident dadr leaves rr_ptr unchanged.
- Back-to-back lookups on 4 consecutive cycles -> 4 consecutive rsp_v_o pulses. A fill on cycle 2 is seen by the request of cycle 3 but not by that of cycle 2.
- inv_all_i with 8 valid entries -> busy_o high for 8 cycles and req_rdy_o low. Afterwards all lookups miss and the next fill goes to entry 0. A fill issued during the sweep is dropped.
- inv_v_i and fill_v_i in the same cycle at dadr 0x2000 -> a subsequent lookup misses. Assert rst_ni low in the middle of the sweep -> busy_o=0 immediately and all entries are invalid.
